// File: rtl/traffic_light_monitor.sv
// Passive protocol checker for a highway/farm traffic-light controller.
// Flags encoding, right-of-way, colour-sequence, yellow-timing and farm-starvation violations.

module traffic_light_monitor_road #(
    parameter int MIN_YELLOW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cur,
    input  logic [2:0] prev,
    input  logic       prev_valid,
    output logic       legal,
    output logic       seq_v,
    output logic       tim_v
);
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam logic [YW-1:0] YSAT = YW'(MIN_YELLOW);

    logic [YW-1:0] ycnt;
    logic          prev_legal;
    logic          checked;

    always_comb begin
        legal      = (cur == RED) || (cur == YEL) || (cur == GRN);
        prev_legal = (prev == RED) || (prev == YEL) || (prev == GRN);
        checked    = prev_valid && legal && prev_legal;
        seq_v      = checked && (((prev == GRN) && (cur == RED)) ||
                                 ((prev == RED) && (cur == YEL)) ||
                                 ((prev == YEL) && (cur == GRN)));
        tim_v      = checked && (prev == YEL) && (cur == RED) && (ycnt < YSAT);
    end

    // Length of the current yellow run, saturated once it is long enough
    always_ff @(posedge clk) begin
        if (rst) begin
            ycnt <= '0;
        end else if (cur == YEL) begin
            if (ycnt != YSAT) ycnt <= ycnt + 1'b1;
        end else begin
            ycnt <= '0;
        end
    end
endmodule

module traffic_light_monitor #(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_WAIT   = 64,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light_highway,
    input  logic [2:0]       light_farm,
    input  logic             C,
    input  logic             clr_err,
    output logic             err_encoding,
    output logic             err_conflict,
    output logic             err_sequence,
    output logic             err_timing,
    output logic             err_starve,
    output logic             viol_pulse,
    output logic [CNT_W-1:0] viol_count
);
    localparam int NUM_ROADS = 2;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] GRN = 3'b001;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    logic [NUM_ROADS-1:0][2:0] cur;
    logic [NUM_ROADS-1:0][2:0] prev;
    logic [NUM_ROADS-1:0]      legal;
    logic [NUM_ROADS-1:0]      seq_v;
    logic [NUM_ROADS-1:0]      tim_v;
    logic                      prev_valid;
    logic                      pending;
    logic [WW-1:0]             wait_cnt;
    logic                      enc_v;
    logic                      conf_v;
    logic                      starve_v;
    logic                      any_v;
    logic [4:0]                new_v;
    logic [4:0]                err;

    // Road 0 is the highway, road 1 the farm road
    assign cur = {light_farm, light_highway};

    for (genvar r = 0; r < NUM_ROADS; r++) begin : g_road
        traffic_light_monitor_road #(.MIN_YELLOW(MIN_YELLOW)) u_road (
            .clk        (clk),
            .rst        (rst),
            .cur        (cur[r]),
            .prev       (prev[r]),
            .prev_valid (prev_valid),
            .legal      (legal[r]),
            .seq_v      (seq_v[r]),
            .tim_v      (tim_v[r])
        );
    end

    always_comb begin
        enc_v    = ~&legal;
        conf_v   = (&legal) && (cur[0] != RED) && (cur[1] != RED);
        starve_v = pending && (light_farm != GRN) && (wait_cnt == WMAX);
        new_v    = {enc_v, conf_v, |seq_v, |tim_v, starve_v};
        any_v    = |new_v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
            prev       <= '0;
        end else begin
            prev_valid <= 1'b1;
            prev       <= cur;
        end
    end

    // One outstanding farm request; further C pulses cannot push the deadline out
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 1'b0;
            wait_cnt <= '0;
        end else if (pending) begin
            if (light_farm == GRN || wait_cnt == WMAX) pending <= 1'b0;
            else                                       wait_cnt <= wait_cnt + 1'b1;
        end else if (C && light_farm == RED) begin
            pending  <= 1'b1;
            wait_cnt <= WW'(1);
        end
    end

    // A violation in the clearing cycle survives the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err        <= '0;
            viol_pulse <= 1'b0;
            viol_count <= '0;
        end else begin
            viol_pulse <= any_v;
            if (clr_err) begin
                err        <= new_v;
                viol_count <= any_v ? CNT_W'(1) : '0;
            end else begin
                err <= err | new_v;
                if (any_v && viol_count != '1) viol_count <= viol_count + 1'b1;
            end
        end
    end

    assign {err_encoding, err_conflict, err_sequence, err_timing, err_starve} = err;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed vector table, starvation/saturation sequences
// and randomized traffic checked against a rule-level reference model.

module tb_traffic_light_monitor;
    localparam int MIN_YELLOW = 3;
    localparam int MAX_WAIT   = 64;
    localparam int CNT_W      = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             C = 1'b0;
    logic             clr_err = 1'b0;
    logic [2:0]       light_highway = R;
    logic [2:0]       light_farm = R;
    logic             err_encoding, err_conflict, err_sequence, err_timing, err_starve;
    logic             viol_pulse;
    logic [CNT_W-1:0] viol_count;
    logic [13:0]      dut_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    traffic_light_monitor #(.MIN_YELLOW(MIN_YELLOW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .light_highway (light_highway),
        .light_farm    (light_farm),
        .C             (C),
        .clr_err       (clr_err),
        .err_encoding  (err_encoding),
        .err_conflict  (err_conflict),
        .err_sequence  (err_sequence),
        .err_timing    (err_timing),
        .err_starve    (err_starve),
        .viol_pulse    (viol_pulse),
        .viol_count    (viol_count)
    );

    assign dut_out = {err_encoding, err_conflict, err_sequence, err_timing, err_starve,
                      viol_pulse, viol_count};

    // Reference model: colour rules, yellow run lengths and request deadlines by edge index
    bit         m_valid = 0;
    logic [2:0] m_prev [2];
    int         m_yrun [2];
    int         m_req = -1;
    int         m_edge = 0;
    logic [4:0] m_flags = '0;
    int         m_cnt = 0;
    bit         m_pulse = 0;

    function automatic bit legal_c(input logic [2:0] x);
        return (x == R) || (x == Y) || (x == G);
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] x);
        if (x == R) return G;
        if (x == G) return Y;
        return R;
    endfunction

    function automatic logic [13:0] model_out();
        return {m_flags, m_pulse, 8'(m_cnt)};
    endfunction

    task automatic model_edge(input logic [2:0] hw, input logic [2:0] farm,
                              input logic c, input logic clr, input logic r);
        logic [2:0] cur [2];
        bit enc, conf, seq, tim, stv;
        logic [4:0] v;
        cur[0] = hw;
        cur[1] = farm;
        if (r) begin
            m_valid = 0; m_yrun[0] = 0; m_yrun[1] = 0; m_req = -1;
            m_flags = '0; m_cnt = 0; m_pulse = 0;
        end else begin
            enc  = !legal_c(hw) || !legal_c(farm);
            conf = legal_c(hw) && legal_c(farm) && hw != R && farm != R;
            seq  = 0;
            tim  = 0;
            for (int i = 0; i < 2; i++) begin
                if (m_valid && legal_c(cur[i]) && legal_c(m_prev[i])) begin
                    if (cur[i] != m_prev[i] && cur[i] != succ(m_prev[i])) seq = 1;
                    if (m_prev[i] == Y && cur[i] == R && m_yrun[i] < MIN_YELLOW) tim = 1;
                end
                m_yrun[i] = (cur[i] == Y) ? m_yrun[i] + 1 : 0;
            end
            stv = 0;
            if (m_req >= 0) begin
                if (farm == G) m_req = -1;
                else if (m_edge - m_req == MAX_WAIT) begin stv = 1; m_req = -1; end
            end else if (c && farm == R) begin
                m_req = m_edge;
            end
            v = {enc, conf, seq, tim, stv};
            m_pulse = (v != 0);
            if (clr) begin
                m_flags = v;
                m_cnt   = m_pulse ? 1 : 0;
            end else begin
                m_flags = m_flags | v;
                if (m_pulse && m_cnt < CNT_MAX) m_cnt++;
            end
            m_prev[0] = hw;
            m_prev[1] = farm;
            m_valid = 1;
        end
        m_edge++;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step(input logic [2:0] hw, input logic [2:0] farm,
                        input logic c, input logic clr, input logic r);
        light_highway = hw; light_farm = farm; C = c; clr_err = clr; rst = r;
        @(posedge clk);
        model_edge(hw, farm, c, clr, r);
        #1;
        check("model", 32'(dut_out), 32'(model_out()));
    endtask

    typedef struct {
        logic [2:0] hw;
        logic [2:0] farm;
        logic [2:0] ctl;    // {C, clr_err, rst}
        logic [4:0] flags;  // {enc, conflict, sequence, timing, starve}
        logic       pulse;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] hw, input logic [2:0] farm, input logic [2:0] ctl,
                                input logic [4:0] f, input logic p, input logic [7:0] n);
        vec_t v;
        v.hw = hw; v.farm = farm; v.ctl = ctl; v.flags = f; v.pulse = p; v.cnt = n;
        return v;
    endfunction

    initial begin
        logic [2:0] hw_c, farm_c;
        // reset, legal cycle, one-cycle conflict
        tbl.push_back(mk(R, R, 3'b001, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(G, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(G, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(Y, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(Y, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(Y, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(R, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(R, G, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(R, Y, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(R, Y, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(R, Y, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(R, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(G, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(Y, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(Y, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(Y, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(Y, G, 3'b000, 5'b01000, 1'b1, 8'd1));
        tbl.push_back(mk(R, G, 3'b000, 5'b01000, 1'b0, 8'd1));
        tbl.push_back(mk(R, G, 3'b000, 5'b01000, 1'b0, 8'd1));
        // clear, then G->R direct
        tbl.push_back(mk(R, Y, 3'b010, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(R, Y, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(R, Y, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(R, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(G, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(R, R, 3'b000, 5'b00100, 1'b1, 8'd1));
        tbl.push_back(mk(R, R, 3'b000, 5'b00100, 1'b0, 8'd1));
        // short yellow
        tbl.push_back(mk(G, R, 3'b010, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(Y, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(Y, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(R, R, 3'b000, 5'b00010, 1'b1, 8'd1));
        tbl.push_back(mk(R, R, 3'b000, 5'b00010, 1'b0, 8'd1));
        // illegal encoding beats clear; no sequence check around it
        tbl.push_back(mk(3'b011, R, 3'b010, 5'b10000, 1'b1, 8'd1));
        tbl.push_back(mk(R, R, 3'b000, 5'b10000, 1'b0, 8'd1));
        // several violations in one cycle count once
        tbl.push_back(mk(G, R, 3'b010, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(Y, Y, 3'b000, 5'b01100, 1'b1, 8'd1));
        tbl.push_back(mk(3'b111, Y, 3'b000, 5'b11100, 1'b1, 8'd2));
        // reset: first cycle afterwards is not sequence checked
        tbl.push_back(mk(G, R, 3'b001, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(R, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(R, Y, 3'b000, 5'b00100, 1'b1, 8'd1));
        // reset in the middle of a yellow run restarts the count
        tbl.push_back(mk(G, R, 3'b001, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(Y, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(Y, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(Y, R, 3'b001, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(Y, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(Y, R, 3'b000, 5'b00000, 1'b0, 8'd0));
        tbl.push_back(mk(R, R, 3'b000, 5'b00010, 1'b1, 8'd1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].hw, tbl[i].farm, tbl[i].ctl[2], tbl[i].ctl[1], tbl[i].ctl[0]);
            check($sformatf("vec%0d", i), 32'(dut_out), 32'({tbl[i].flags, tbl[i].pulse, tbl[i].cnt}));
        end

        // farm green on the last allowed edge
        step(R, R, 1'b0, 1'b0, 1'b1);
        step(R, R, 1'b0, 1'b0, 1'b0);
        step(R, R, 1'b1, 1'b0, 1'b0);
        for (int j = 1; j < MAX_WAIT; j++) step(R, R, 1'b0, 1'b0, 1'b0);
        step(R, G, 1'b0, 1'b0, 1'b0);
        check("starve_edge_green", 32'(err_starve), 32'd0);
        step(R, G, 1'b0, 1'b0, 1'b0);
        check("starve_after_green", 32'({err_starve, viol_count}), 32'd0);

        // farm held red; a second request does not extend the deadline
        step(R, R, 1'b0, 1'b0, 1'b1);
        step(R, R, 1'b0, 1'b0, 1'b0);
        step(R, R, 1'b1, 1'b0, 1'b0);
        for (int j = 1; j < MAX_WAIT; j++) step(R, R, (j == 30), 1'b0, 1'b0);
        check("starve_early", 32'(err_starve), 32'd0);
        step(R, R, 1'b0, 1'b0, 1'b0);
        check("starve_deadline", 32'({err_starve, viol_pulse, viol_count}), 32'({2'b11, 8'd1}));
        step(R, G, 1'b0, 1'b0, 1'b0);
        check("starve_sticky", 32'({err_starve, viol_pulse}), 32'b10);

        // counter saturation, pulse still fires
        step(R, R, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < CNT_MAX + 40; j++) step(3'b000, R, 1'b0, 1'b0, 1'b0);
        check("sat_count", 32'({viol_pulse, viol_count}), 32'({1'b1, 8'hFF}));
        step(R, R, 1'b0, 1'b1, 1'b0);
        check("sat_clear", 32'({err_encoding, viol_pulse, viol_count}), 32'd0);

        // randomized traffic against the model
        step(R, R, 1'b0, 1'b0, 1'b1);
        hw_c = R;
        farm_c = R;
        for (int n = 0; n < 3000; n++) begin
            int p;
            p = $urandom_range(0, 99);
            if (p >= 65 && p < 85)      hw_c = succ(hw_c);
            else if (p >= 85 && p < 95) hw_c = 3'b001 << $urandom_range(0, 2);
            else if (p >= 95)           hw_c = 3'($urandom_range(0, 7));
            p = $urandom_range(0, 99);
            if (p >= 75 && p < 90)      farm_c = succ(farm_c);
            else if (p >= 90 && p < 97) farm_c = 3'b001 << $urandom_range(0, 2);
            else if (p >= 97)           farm_c = 3'($urandom_range(0, 7));
            step(hw_c, farm_c, ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 599) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
